tuss_burst_drv: RTL

- Upstream-facing burst driver between the detection controller and the TUSS transducer driver chip.
- Turns a `burst_en` request into a counted train of square pulses on the chip's io1/io2 pins.
- Signals completion with a single-cycle `burst_finish`.
- Latches a pulse-count fault (PULSE_NUM_FLT) when the requested count is illegal; the controller's handshake still completes.

---
 rtl/ultra_pkg.sv | 20 ++
 rtl/burst_half_timer.sv | 40 ++++
 rtl/tuss_burst_drv.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ultra_pkg.sv
// Shared types and defaults for the TUSS burst driver slice.
// Holds the burst FSM state encoding and the io2 drive mode encodings.
package ultra_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HIGH  = 3'd1,
        LOW   = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } burst_state_e;

    localparam int HALF_PERIOD_DEF = 625;  // 40 kHz at 50 MHz gclk
    localparam int PULSE_MAX_DEF   = 16;
    localparam int NUM_W_DEF       = 5;

    localparam int IO_MODE_COMP   = 0;  // io2 complementary to io1
    localparam int IO_MODE_SINGLE = 1;  // io2 held low

endpackage

// File: rtl/burst_half_timer.sv
// Counts HALF_PERIOD enabled cycles and strobes half_done on the last one,
// wrapping to zero so consecutive halves run back to back.
module burst_half_timer
    import ultra_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEF
) (
    input  logic gclk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic half_done
);

    localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [TW-1:0] LAST = TW'(HALF_PERIOD - 1);

    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;

    assign half_done = enable & ~clear & (tick_q == LAST);

    always_comb begin
        tick_d = tick_q;
        if (clear) begin
            tick_d = '0;
        end else if (enable) begin
            tick_d = half_done ? '0 : tick_q + TW'(1);
        end
    end

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/tuss_burst_drv.sv
// Burst driver: turns a burst_en rising edge into N square pulses on io1/io2,
// then strobes burst_finish; illegal counts latch a sticky fault instead.
module tuss_burst_drv
    import ultra_pkg::*;
#(
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int PULSE_MAX   = PULSE_MAX_DEF,
    parameter int NUM_W       = NUM_W_DEF,
    parameter int IO_MODE     = IO_MODE_COMP
) (
    input  logic             gclk,
    input  logic             rstn,
    input  logic             burst_rstn,
    input  logic             burst_en,
    input  logic [NUM_W-1:0] pulse_num_i,
    output logic             io1,
    output logic             io2,
    output logic             burst_finish,
    output logic             busy,
    output logic [NUM_W-1:0] pulse_cnt_o,
    output logic             pulse_num_flt
);

    localparam logic [NUM_W-1:0] PMAX = NUM_W'(PULSE_MAX);

    burst_state_e     state_q, state_d;
    logic             en_dly_q, en_dly_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] cnt_q, cnt_d;
    logic             flt_q, flt_d;
    logic             io1_q, io1_d;
    logic             io2_q, io2_d;
    logic             busy_q, busy_d;
    logic             finish_q, finish_d;

    logic start;
    logic abort;
    logic num_ok;
    logic tmr_clear;
    logic tmr_en;
    logic half_done;

    // Only a rising edge starts a burst, so the trailing high cycle after finish is inert.
    assign start  = burst_en & ~en_dly_q;
    assign abort  = ~burst_rstn;
    assign num_ok = (pulse_num_i != '0) && (pulse_num_i <= PMAX);
    assign tmr_en = (state_q == HIGH) || (state_q == LOW);

    burst_half_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_timer (
        .gclk      (gclk),
        .rstn      (rstn),
        .clear     (tmr_clear),
        .enable    (tmr_en),
        .half_done (half_done)
    );

    always_comb begin
        state_d   = state_q;
        en_dly_d  = burst_en;
        num_d     = num_q;
        cnt_d     = cnt_q;
        flt_d     = flt_q;
        tmr_clear = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        num_d = pulse_num_i;
                        if (num_ok) begin
                            state_d   = HIGH;
                            cnt_d     = '0;
                            tmr_clear = 1'b1;
                        end else begin
                            state_d = FAULT;
                            flt_d   = 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (half_done) begin
                        state_d = LOW;
                        cnt_d   = cnt_q + NUM_W'(1);
                    end
                end
                LOW: begin
                    if (half_done) begin
                        state_d = (cnt_q == num_q) ? DONE : HIGH;
                    end
                end
                DONE:    state_d = IDLE;
                FAULT:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered alongside the state they belong to.
        io1_d    = (state_d == HIGH);
        io2_d    = (IO_MODE == IO_MODE_COMP) && (state_d == LOW);
        busy_d   = (state_d == HIGH) || (state_d == LOW);
        finish_d = (state_d == DONE) || (state_d == FAULT);
    end

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            en_dly_q <= 1'b0;
            num_q    <= '0;
            cnt_q    <= '0;
            flt_q    <= 1'b0;
            io1_q    <= 1'b0;
            io2_q    <= 1'b0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_dly_q <= en_dly_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            flt_q    <= flt_d;
            io1_q    <= io1_d;
            io2_q    <= io2_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign io1           = io1_q;
    assign io2           = io2_q;
    assign burst_finish  = finish_q;
    assign busy          = busy_q;
    assign pulse_cnt_o   = cnt_q;
    assign pulse_num_flt = flt_q;

endmodule
